// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: state encodings,
// the NOP word shown before the first fetch, and the default reset PC.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Combinational next-PC selection for a completed instruction, including
// the halt request and the branch-target misalignment trap.
module fetch_unit_pc_next_sel (
    input  logic [31:0] pc,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    input  logic        halt_flag,
    output logic [31:0] pc_next,
    output logic        to_halt,
    output logic        trap,
    output logic        retire
);

    logic [31:0] tgt;

    always_comb begin
        // Bit 0 is cleared as JALR requires; bit 1 set means not word aligned.
        tgt     = {branch_target[31:1], 1'b0};
        pc_next = pc + 32'd4;
        to_halt = 1'b0;
        trap    = 1'b0;
        retire  = 1'b1;
        if (halt_flag) begin
            pc_next = pc;
            to_halt = 1'b1;
        end else if (branch_en) begin
            if (tgt[1]) begin
                pc_next = pc;
                to_halt = 1'b1;
                trap    = 1'b1;
                retire  = 1'b0;
            end else begin
                pc_next = tgt;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem over a req/ack handshake,
// holds the instruction for the decoder and steps the PC on exec_done.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        inst,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               inst_valid,
    input  logic               exec_done,
    input  logic               branchEn,
    input  logic [31:0]        branch_target,
    input  logic               halt_flag,
    output logic               halted,
    output logic               misaligned,
    output logic [COUNT_W-1:0] instret,
    output logic [COUNT_W-1:0] cycles
);

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;
    logic               mis_q, mis_d;
    logic [COUNT_W-1:0] instret_q, instret_d;
    logic [COUNT_W-1:0] cycles_q, cycles_d;

    logic        ack_take, exec_take;
    logic [31:0] sel_pc;
    logic        sel_halt, sel_trap, sel_retire;

    // An ack only counts while a request is actually outstanding.
    assign ack_take  = (state_q == FETCH) && req_q && imem_ack;
    assign exec_take = (state_q == ISSUE) && exec_done;

    fetch_unit_pc_next_sel u_pc_next_sel (
        .pc            (pc_q),
        .branch_en     (branchEn),
        .branch_target (branch_target),
        .halt_flag     (halt_flag),
        .pc_next       (sel_pc),
        .to_halt       (sel_halt),
        .trap          (sel_trap),
        .retire        (sel_retire)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:   if (ack_take)  state_d = ISSUE;
            ISSUE:   if (exec_take) state_d = sel_halt ? HALTED : FETCH;
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        inst_d    = inst_q;
        mis_d     = mis_q;
        instret_d = instret_q;
        cycles_d  = cycles_q;
        // Handshake outputs are registered so they follow the next state.
        req_d     = (state_d == FETCH);
        valid_d   = (state_d == ISSUE);
        if (ack_take) inst_d = imem_rdata;
        if (exec_take) begin
            pc_d = sel_pc;
            if (sel_trap)   mis_d     = 1'b1;
            if (sel_retire) instret_d = instret_q + CNT_ONE;
        end
        if (state_q != HALTED) cycles_d = cycles_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
            instret_q <= instret_d;
            cycles_q  <= cycles_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign inst_valid = valid_q;
    assign halted     = (state_q == HALTED);
    assign misaligned = mis_q;
    assign instret    = instret_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: fetched words go through a scoreboard
// queue, PC/counter expectations come from a small reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst, pc, pc_plus4;
    logic        inst_valid;
    logic        exec_done = 1'b0;
    logic        branchEn = 1'b0;
    logic [31:0] branch_target = '0;
    logic        halt_flag = 1'b0;
    logic        halted, misaligned;
    logic [31:0] instret, cycles;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc      = '0;
    logic [31:0] m_instret = '0;
    logic [31:0] m_cycles  = '0;
    logic        m_halted  = 1'b0;
    logic        m_mis     = 1'b0;
    logic [63:0] sb_q[$];

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .pc(pc), .pc_plus4(pc_plus4), .inst_valid(inst_valid),
        .exec_done(exec_done), .branchEn(branchEn),
        .branch_target(branch_target), .halt_flag(halt_flag),
        .halted(halted), .misaligned(misaligned),
        .instret(instret), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: counts every edge out of reset until halted.
    always @(posedge clk) begin
        if (rst)            m_cycles <= '0;
        else if (!m_halted) m_cycles <= m_cycles + 32'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        m_pc = '0; m_instret = '0; m_halted = 1'b0; m_mis = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_fetch(input int dly, input logic [31:0] data);
        logic [63:0] e;
        int t = 0;
        while (!imem_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", imem_req, 1'b1);
        check("imem_addr", imem_addr, m_pc);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("addr_hold", {imem_req, imem_addr}, {1'b1, m_pc});
        end
        imem_ack = 1'b1;
        imem_rdata = data;
        sb_q.push_back({m_pc, data});
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("inst_valid", {inst_valid, imem_req}, 2'b10);
        e = sb_q.pop_front();
        check("inst_pc", {pc, inst}, e);
        check("pc_plus4", pc_plus4, e[63:32] + 32'd4);
    endtask

    task automatic do_exec(input logic br, input logic [31:0] tgt, input logic hlt);
        logic [31:0] t;
        exec_done = 1'b1; branchEn = br; branch_target = tgt; halt_flag = hlt;
        @(negedge clk);
        exec_done = 1'b0; branchEn = 1'b0; branch_target = '0; halt_flag = 1'b0;
        t = {tgt[31:1], 1'b0};
        if (hlt) begin
            m_instret++; m_halted = 1'b1;
        end else if (br && t[1]) begin
            m_mis = 1'b1; m_halted = 1'b1;
        end else begin
            m_pc = br ? t : m_pc + 32'd4;
            m_instret++;
        end
        check("exec_pc", pc, m_pc);
        check("exec_hs", {inst_valid, imem_req}, {1'b0, !m_halted});
        check("exec_flags", {halted, misaligned}, {m_halted, m_mis});
        check("instret", instret, m_instret);
        check("cycles", cycles, m_cycles);
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);
        check("rst_state", {imem_req, inst_valid, halted, misaligned}, 4'b0000);
        check("rst_inst_pc", {inst, pc}, {32'h0000_0013, 32'h0});
        check("rst_counts", {instret, cycles}, 64'h0);
        @(negedge clk);
        check("first_req", {imem_req, imem_addr}, {1'b1, 32'h0});

        // Zero-wait sequential fetch, then 3-cycle ack delay.
        do_fetch(0, 32'h0050_0093); do_exec(1'b0, 32'h0, 1'b0);
        do_fetch(0, 32'h0050_0093); do_exec(1'b0, 32'h0, 1'b0);
        check("seq_pc8", pc, 32'h8);
        do_fetch(3, 32'h0010_0113); do_exec(1'b0, 32'h0, 1'b0);
        do_fetch(3, 32'h0020_0193);

        // Branches: plain target, then JALR with bit 0 set.
        do_exec(1'b1, 32'h100, 1'b0);
        do_fetch(1, 32'h0000_0067); do_exec(1'b1, 32'h101, 1'b0);
        check("jalr_pc", pc, 32'h100);
        do_fetch(0, 32'h0000_0063);

        // Misaligned target traps and halts without retiring.
        do_exec(1'b1, 32'h102, 1'b0);
        repeat (3) @(negedge clk);
        check("mis_hold", {imem_req, halted, misaligned, pc}, {3'b011, 32'h100});

        // Halt has priority over a simultaneous branch.
        do_reset(2);
        do_fetch(0, 32'h0000_0073);
        do_exec(1'b1, 32'h200, 1'b1);
        repeat (10) @(negedge clk);
        check("halt_cycles", cycles, m_cycles);
        exec_done = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        exec_done = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        check("halt_ignore", {imem_req, inst_valid, halted, misaligned}, 4'b0010);
        check("halt_state", {pc, instret}, {m_pc, m_instret});
        check("halt_inst", inst, 32'h0000_0073);

        // Reset mid-fetch with an ack arriving during reset.
        do_reset(1);
        do_fetch(0, 32'h0050_0093); do_exec(1'b0, 32'h0, 1'b0);
        do_fetch(2, 32'h0050_0093); do_exec(1'b0, 32'h0, 1'b0);
        check("pre_rst", {imem_req, imem_addr}, {1'b1, 32'h8});
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        do_reset(0);
        check("mid_rst", {imem_req, inst_valid, pc, inst}, {2'b00, 32'h0, 32'h0000_0013});
        check("mid_rst_cnt", {instret, cycles}, 64'h0);
        do_fetch(0, 32'h0000_0013);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
